// File: rtl/key_command_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : key_command_decoder
//  Description : Debounced key levels -> single command tokens on a
//                valid/ready handshake, with optional direction auto-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_command_decoder #(
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] keyin,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic       busy
);

    localparam int c_MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_CNT_W   = (c_MAX_CNT < 1) ? 1 : $clog2(c_MAX_CNT + 1);
    localparam bit c_REPEAT_EN = (REPEAT_DELAY > 0);
    localparam logic [c_CNT_W-1:0] c_DELAY_M1 = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_RATE_M1  = c_CNT_W'(REPEAT_RATE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = '1;
    // Synchroniser resets to the raw "pressed" level so held keys look already down.
    localparam logic [5:0] c_SYNC_RST = (ACTIVE_LOW != 0) ? 6'b000000 : 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [5:0]           r_sync1_q, r_sync2_q, r_prev_q, r_edge_q;
    logic [5:0]           w_edge_d, w_key_s;
    logic [2:0]           r_cmd_q, w_cmd_d, w_pick;
    logic                 r_cmd_valid_q, w_cmd_valid_d;
    logic                 r_busy_q, w_busy_d;
    logic                 r_first_q, w_first_d;
    logic [c_CNT_W-1:0]   r_rep_cnt_q, w_rep_cnt_d, w_target;

    always_comb begin
        w_key_s  = (ACTIVE_LOW != 0) ? ~r_sync2_q : r_sync2_q;
        // Edges seen outside IDLE are dropped rather than queued.
        w_edge_d = (r_state_q == S_IDLE) ? (w_key_s & ~r_prev_q) : 6'b000000;
        w_pick   = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (r_edge_q[i]) begin
                w_pick = 3'(i);
            end
        end
        w_target = r_first_q ? c_DELAY_M1 : c_RATE_M1;
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_cmd_d       = r_cmd_q;
        w_cmd_valid_d = r_cmd_valid_q;
        w_first_d     = r_first_q;
        w_rep_cnt_d   = r_rep_cnt_q;
        unique case (r_state_q)
            S_IDLE: begin
                if (|r_edge_q) begin
                    w_cmd_d       = w_pick;
                    w_cmd_valid_d = 1'b1;
                    w_first_d     = 1'b1;
                    w_state_d     = S_PEND;
                end
            end
            S_PEND: begin
                if (cmd_ready) begin
                    w_cmd_valid_d = 1'b0;
                    w_rep_cnt_d   = '0;
                    w_state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_key_s[r_cmd_q]) begin
                    w_state_d = S_IDLE;
                end else if (c_REPEAT_EN && (r_cmd_q <= 3'd3)) begin
                    if (r_rep_cnt_q == w_target) begin
                        w_cmd_valid_d = 1'b1;
                        w_first_d     = 1'b0;
                        w_state_d     = S_PEND;
                    end else if (r_rep_cnt_q != c_CNT_SAT) begin
                        w_rep_cnt_d = r_rep_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q     <= c_SYNC_RST;
            r_sync2_q     <= c_SYNC_RST;
            r_prev_q      <= 6'b111111;
            r_edge_q      <= 6'b000000;
            r_state_q     <= S_IDLE;
            r_cmd_q       <= 3'd0;
            r_cmd_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_first_q     <= 1'b0;
            r_rep_cnt_q   <= '0;
        end else begin
            r_sync1_q     <= keyin;
            r_sync2_q     <= r_sync1_q;
            r_prev_q      <= w_key_s;
            r_edge_q      <= w_edge_d;
            r_state_q     <= w_state_d;
            r_cmd_q       <= w_cmd_d;
            r_cmd_valid_q <= w_cmd_valid_d;
            r_busy_q      <= w_busy_d;
            r_first_q     <= w_first_d;
            r_rep_cnt_q   <= w_rep_cnt_d;
        end
    end

    assign cmd_valid = r_cmd_valid_q;
    assign cmd       = r_cmd_q;
    assign busy      = r_busy_q;

endmodule
`default_nettype wire
